// File: rtl/vliw_pkg.sv
// Shared types and helpers for the VLIW forwarding/interlock scoreboard.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// An entry records one in-flight lane result. Its fields are sized to cover
// every legal module parameterisation. Narrower register and latency fields
// are zero-extended when an entry is loaded.
package vliw_pkg;

    // Forwarding source stage indices.
    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    // Storage widths of the entry fields. They must be at least REG_W/LAT_W.
    localparam int ENT_REG_W = 8;
    localparam int ENT_LAT_W = 4;

    typedef struct packed {
        logic                 wr;   // entry will write rd
        logic [ENT_REG_W-1:0] rd;   // destination register
        logic [ENT_LAT_W-1:0] lat;  // first stage where the result is forwardable
    } entry_t;

    // Select code for a producer at (stage, lane). 0 is reserved for the
    // register file. Within a stage, higher lanes get smaller codes. At
    // 2 lanes this gives EX:2/1, MEM:4/3, WB:6/5.
    function automatic int sel_encode(input int stage, input int lane, input int lanes);
        return 1 + stage * lanes + (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/vliw_fwd_scoreboard_fwd_sel_lane.sv
// Per-operand forwarding priority search over all shadow-pipeline entries.
// Latency: purely combinational; sel/hazard are valid in the same cycle as src.
// Backpressure: none; hazard feeds the bundle-wide stall in the parent.
//
// Ports:
//   en     - the owning lane holds a valid instruction. It gates hazard only.
//   src    - source register index being looked up.
//   ent    - all entries, flattened as index stage*LANES + lane.
//   sel    - winning select code. 0 means no match (register file).
//   hazard - the winner's result is not yet forwardable at its current stage.
module fwd_sel_lane
    import vliw_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int STAGES = 3,
    parameter int REG_W  = 5,
    parameter int SEL_W  = 3
) (
    input  logic                          en,
    input  logic [REG_W-1:0]              src,
    input  entry_t [STAGES*LANES-1:0]     ent,
    output logic [SEL_W-1:0]              sel,
    output logic                          hazard
);

    logic [ENT_REG_W-1:0] src_ext;
    logic                 hit_late;

    assign src_ext = ENT_REG_W'(src);

    // Scan from the lowest priority to the highest and let later hits overwrite
    // earlier ones. The oldest stage is scanned first, and within a stage lane 0
    // is scanned first. The last hit left standing is therefore the youngest
    // stage, highest lane.
    always_comb begin
        sel      = '0;
        hit_late = 1'b0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (ent[s*LANES+l].wr && (ent[s*LANES+l].rd == src_ext) && (src != '0)) begin
                    sel      = SEL_W'(sel_encode(s, l, LANES));
                    hit_late = (int'(ent[s*LANES+l].lat) > s);
                end
            end
        end
    end

    assign hazard = en & hit_late;

endmodule

// File: rtl/vliw_fwd_scoreboard.sv
// VLIW issue-stage forwarding selector and load-use interlock.
// Latency: fwd_a/fwd_b/stall/issue are combinational; the shadow pipeline advances each clk.
// Backpressure: stall holds decode/fetch. A stalled or flushed cycle pushes a bubble into EX.
//
// Ports:
//   clk, rst_n      - rising-edge clock; async active-low reset (release synchronised upstream)
//   dec_valid/wr    - per-lane valid and write-enable of the decode bundle
//   dec_rs1/rs2/rd  - per-lane register indices, lane i at [i*REG_W +: REG_W]
//   dec_lat         - per-lane first forwardable stage (0 = ALU, 1 = load), clamped to STAGES-1
//   flush           - kill all in-flight entries; suppresses issue and stall this cycle
//   issue, stall    - bundle enters EX / decode must hold
//   fwd_a, fwd_b    - per-lane operand selects, lane i at [i*SEL_W +: SEL_W]
//   stall_cnt       - saturating count of stalled cycles
module vliw_fwd_scoreboard
    import vliw_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int STAGES = 3,
    parameter int REG_W  = 5,
    parameter int LAT_W  = 2,
    parameter int SEL_W  = $clog2(STAGES * LANES + 1),
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LANES-1:0]         dec_valid,
    input  logic [LANES*REG_W-1:0]   dec_rs1,
    input  logic [LANES*REG_W-1:0]   dec_rs2,
    input  logic [LANES*REG_W-1:0]   dec_rd,
    input  logic [LANES-1:0]         dec_wr,
    input  logic [LANES*LAT_W-1:0]   dec_lat,
    input  logic                     flush,
    output logic                     issue,
    output logic                     stall,
    output logic [LANES*SEL_W-1:0]   fwd_a,
    output logic [LANES*SEL_W-1:0]   fwd_b,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int NENT = STAGES * LANES;

    entry_t [NENT-1:0]  ent_q;
    entry_t [LANES-1:0] dec_ent;
    logic   [LANES-1:0] haz_a;
    logic   [LANES-1:0] haz_b;

    // Build the entries this bundle would push into EX. Latencies beyond the
    // last stage are clamped so that such a producer still becomes forwardable
    // at WB instead of interlocking forever.
    always_comb begin
        dec_ent = '0;
        for (int l = 0; l < LANES; l++) begin
            dec_ent[l].wr = dec_valid[l] & dec_wr[l];
            dec_ent[l].rd = ENT_REG_W'(dec_rd[l*REG_W +: REG_W]);
            if (int'(dec_lat[l*LAT_W +: LAT_W]) >= STAGES) begin
                dec_ent[l].lat = ENT_LAT_W'(STAGES - 1);
            end else begin
                dec_ent[l].lat = ENT_LAT_W'(dec_lat[l*LAT_W +: LAT_W]);
            end
        end
    end

    // One search per lane and operand. Only registered entries are searched,
    // so a lane never sees a same-bundle producer. Within a bundle, reads
    // happen before writes.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fwd_sel_lane #(
            .LANES  (LANES),
            .STAGES (STAGES),
            .REG_W  (REG_W),
            .SEL_W  (SEL_W)
        ) u_sel_a (
            .en     (dec_valid[g]),
            .src    (dec_rs1[g*REG_W +: REG_W]),
            .ent    (ent_q),
            .sel    (fwd_a[g*SEL_W +: SEL_W]),
            .hazard (haz_a[g])
        );

        fwd_sel_lane #(
            .LANES  (LANES),
            .STAGES (STAGES),
            .REG_W  (REG_W),
            .SEL_W  (SEL_W)
        ) u_sel_b (
            .en     (dec_valid[g]),
            .src    (dec_rs2[g*REG_W +: REG_W]),
            .ent    (ent_q),
            .sel    (fwd_b[g*SEL_W +: SEL_W]),
            .hazard (haz_b[g])
        );
    end

    // Flush overrides the interlock. The bundle is being discarded anyway, so
    // holding decode would only delay the redirect.
    assign stall = ((|haz_a) | (|haz_b)) & ~flush;
    assign issue = (|dec_valid) & ~stall & ~flush;

    // Shadow pipeline. Entries leaving the last stage are dropped because the
    // register file write-through already covers them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else if (flush) begin
            ent_q <= '0;
        end else begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    ent_q[s*LANES+l] <= ent_q[(s-1)*LANES+l];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                ent_q[EX*LANES+l] <= issue ? dec_ent[l] : '0;
            end
        end
    end

    // Saturating stall-cycle counter. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vliw_fwd_scoreboard.sv
module tb_vliw_fwd_scoreboard;

    localparam int LANES = 2;
    localparam int REG_W = 5;
    localparam int LAT_W = 2;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic [LANES-1:0]       dec_valid;
    logic [LANES*REG_W-1:0] dec_rs1;
    logic [LANES*REG_W-1:0] dec_rs2;
    logic [LANES*REG_W-1:0] dec_rd;
    logic [LANES-1:0]       dec_wr;
    logic [LANES*LAT_W-1:0] dec_lat;
    logic                   flush;
    logic                   issue;
    logic                   stall;
    logic [LANES*SEL_W-1:0] fwd_a;
    logic [LANES*SEL_W-1:0] fwd_b;
    logic [CNT_W-1:0]       stall_cnt;

    vliw_fwd_scoreboard #(
        .LANES  (LANES),
        .STAGES (3),
        .REG_W  (REG_W),
        .LAT_W  (LAT_W),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec_valid (dec_valid),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .dec_wr    (dec_wr),
        .dec_lat   (dec_lat),
        .flush     (flush),
        .issue     (issue),
        .stall     (stall),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [1:0] vld;
        logic [4:0] rs1_0, rs1_1, rs2_0, rs2_1, rd_0, rd_1;
        logic [1:0] wr;
        logic [1:0] lat_0, lat_1;
        logic       fl;
        logic       e_issue, e_stall;
        logic [2:0] e_a0, e_a1, e_b0, e_b1;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;
    vec_t vt[16];

    function automatic vec_t mk(string n, logic [1:0] vld,
                                int r10, int r11, int r20, int r21, int d0, int d1,
                                logic [1:0] wr, int l0, int l1, logic fl,
                                logic ei, logic es, int a0, int a1, int b0, int b1);
        vec_t v;
        v.name = n;  v.vld = vld;
        v.rs1_0 = 5'(r10); v.rs1_1 = 5'(r11);
        v.rs2_0 = 5'(r20); v.rs2_1 = 5'(r21);
        v.rd_0 = 5'(d0);   v.rd_1 = 5'(d1);
        v.wr = wr; v.lat_0 = 2'(l0); v.lat_1 = 2'(l1); v.fl = fl;
        v.e_issue = ei; v.e_stall = es;
        v.e_a0 = 3'(a0); v.e_a1 = 3'(a1); v.e_b0 = 3'(b0); v.e_b1 = 3'(b1);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dec_valid = v.vld;
        dec_rs1   = {v.rs1_1, v.rs1_0};
        dec_rs2   = {v.rs2_1, v.rs2_0};
        dec_rd    = {v.rd_1, v.rd_0};
        dec_wr    = v.wr;
        dec_lat   = {v.lat_1, v.lat_0};
        flush     = v.fl;
    endtask

    // Advance the expected counter by one cycle's expected stall.
    task automatic count_stall(input logic s);
        if (s && exp_cnt < 15) exp_cnt++;
    endtask

    initial begin
        vec_t v;

        //            name               vld   rs1_0 rs1_1 rs2_0 rs2_1 rd0 rd1 wr    l0 l1 fl  iss stl a0 a1 b0 b1
        vt[0]  = mk("alu_wr_r5",        2'b01, 0, 0, 0, 0, 5, 0, 2'b01, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vt[1]  = mk("ex_fwd_lane1",     2'b10, 0, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 2, 0, 0);
        vt[2]  = mk("mem_fwd",          2'b11, 5, 0, 0, 5, 0, 0, 2'b00, 0, 0, 0,  1, 0, 4, 0, 0, 4);
        vt[3]  = mk("wb_fwd_dual_wr7",  2'b11, 0, 0, 5, 0, 7, 7, 2'b11, 0, 0, 0,  1, 0, 0, 0, 6, 0);
        vt[4]  = mk("lane_prio_r7",     2'b11, 7, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        vt[5]  = mk("intra_bundle",     2'b11, 7, 0, 0, 9, 9, 0, 2'b11, 0, 0, 0,  1, 0, 3, 0, 0, 0);
        vt[6]  = mk("r0_ign_load_r3",   2'b11, 0, 9, 7, 0, 3, 0, 2'b01, 1, 0, 0,  1, 0, 0, 2, 5, 0);
        vt[7]  = mk("load_use_stall",   2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0,  0, 1, 2, 0, 0, 0);
        vt[8]  = mk("load_use_issue",   2'b01, 3, 0, 0, 0, 3, 0, 2'b01, 1, 0, 0,  1, 0, 4, 0, 0, 0);
        vt[9]  = mk("flush_in_stall",   2'b01, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1,  0, 0, 2, 0, 0, 0);
        vt[10] = mk("post_flush",       2'b11, 3, 3, 3, 0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        vt[11] = mk("clamp_load_r4",    2'b10, 0, 0, 0, 0, 0, 4, 2'b10, 0, 3, 0,  1, 0, 0, 0, 0, 0);
        vt[12] = mk("clamp_ex",         2'b01, 0, 0, 4, 0, 0, 0, 2'b00, 0, 0, 0,  0, 1, 0, 0, 1, 0);
        vt[13] = mk("clamp_mem",        2'b01, 0, 0, 4, 0, 0, 0, 2'b00, 0, 0, 0,  0, 1, 0, 0, 3, 0);
        vt[14] = mk("clamp_wb_ld_r6",   2'b01, 0, 0, 4, 0, 6, 0, 2'b01, 1, 0, 0,  1, 0, 0, 0, 5, 0);
        vt[15] = mk("invalid_lane_haz", 2'b01, 0, 6, 0, 0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 0, 2, 0, 0);

        // Reset state with a valid bundle presented.
        rst_n = 1'b0;
        v = mk("idle", 2'b11, 1, 2, 3, 4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        #3;
        check("rst_issue", 32'(issue), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_cnt",   32'(stall_cnt), 32'd0);
        dec_valid = 2'b00;
        #9 rst_n = 1'b1;

        // Table-driven directed sequence. State carries between rows.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(vt[i]);
            @(negedge clk);
            check($sformatf("%s.issue", vt[i].name), 32'(issue), 32'(vt[i].e_issue));
            check($sformatf("%s.stall", vt[i].name), 32'(stall), 32'(vt[i].e_stall));
            check($sformatf("%s.a0", vt[i].name), 32'(fwd_a[2:0]), 32'(vt[i].e_a0));
            check($sformatf("%s.a1", vt[i].name), 32'(fwd_a[5:3]), 32'(vt[i].e_a1));
            check($sformatf("%s.b0", vt[i].name), 32'(fwd_b[2:0]), 32'(vt[i].e_b0));
            check($sformatf("%s.b1", vt[i].name), 32'(fwd_b[5:3]), 32'(vt[i].e_b1));
            check($sformatf("%s.cnt", vt[i].name), 32'(stall_cnt), 32'(exp_cnt));
            count_stall(vt[i].e_stall);
        end

        // Self-dependent load with lat=3 (clamped to WB) held constant: pattern
        // issue, stall, stall repeats, driving the 4-bit counter into saturation.
        v = mk("sat", 2'b01, 3, 0, 0, 0, 3, 0, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            logic       es;
            logic [2:0] ea;
            @(posedge clk); #1;
            drive(v);
            @(negedge clk);
            es = (i % 3) != 0;
            ea = (i % 3 == 1) ? 3'd2 : (i % 3 == 2) ? 3'd4 : (i == 0) ? 3'd0 : 3'd6;
            check($sformatf("sat%0d.stall", i), 32'(stall), 32'(es));
            check($sformatf("sat%0d.issue", i), 32'(issue), 32'(!es));
            check($sformatf("sat%0d.a0", i), 32'(fwd_a[2:0]), 32'(ea));
            check($sformatf("sat%0d.cnt", i), 32'(stall_cnt), 32'(exp_cnt));
            count_stall(es);
        end

        // Async reset in the middle of the last load-use stall.
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_issue", 32'(issue), 32'd1);
        check("midrst_cnt",   32'(stall_cnt), 32'd0);
        check("midrst_fwd_a", 32'(fwd_a), 32'd0);
        check("midrst_fwd_b", 32'(fwd_b), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_a0",    32'(fwd_a[2:0]), 32'd0);
        check("postrst_stall", 32'(stall), 32'd0);
        check("postrst_issue", 32'(issue), 32'd1);
        check("postrst_cnt",   32'(stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
